// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired x0, writeback-to-read bypass and a
// per-register pending-write scoreboard for decode hazard detection.
module regfile_scoreboard #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] Read_Data_1,
    output logic [XLEN-1:0] Read_Data_2,
    input  logic [AW-1:0]   rd,
    input  logic            RegWrite,
    input  logic [XLEN-1:0] Write_Data,
    input  logic            Busy_Set,
    input  logic [AW-1:0]   Busy_rd,
    output logic            rs1_Busy,
    output logic            rs2_Busy,
    input  logic [AW-1:0]   Dbg_Addr,
    output logic [XLEN-1:0] Dbg_Data,
    output logic [AW:0]     Busy_Count
);

    localparam int NREG = 2**AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     count_next;
    logic            wr_en;

    assign wr_en = RegWrite && (rd != '0);

    // Set is applied after clear so a same-cycle reissue keeps the bit high.
    always_comb begin
        busy_next = busy;
        if (wr_en)
            busy_next[rd] = 1'b0;
        if (Busy_Set && (Busy_rd != '0))
            busy_next[Busy_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        count_next = '0;
        for (int i = 1; i < NREG; i++)
            count_next = count_next + {{AW{1'b0}}, busy_next[i]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy       <= '0;
            Busy_Count <= '0;
        end else begin
            if (wr_en)
                regs[rd] <= Write_Data;
            busy       <= busy_next;
            Busy_Count <= count_next;
        end
    end

    // Bypass is suppressed during reset so every output reads zero.
    always_comb begin
        Read_Data_1 = '0;
        Read_Data_2 = '0;
        if (rs1 != '0)
            Read_Data_1 = (!reset && wr_en && (rd == rs1)) ? Write_Data : regs[rs1];
        if (rs2 != '0)
            Read_Data_2 = (!reset && wr_en && (rd == rs2)) ? Write_Data : regs[rs2];
    end

    assign rs1_Busy = busy[rs1] && !(wr_en && (rd == rs1));
    assign rs2_Busy = busy[rs2] && !(wr_en && (rd == rs2));
    assign Dbg_Data = (Dbg_Addr == '0) ? '0 : regs[Dbg_Addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed corner cases followed by
// random traffic, checked against an array-based reference model.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   rs1 = '0, rs2 = '0, rd = '0, Busy_rd = '0, Dbg_Addr = '0;
    logic            RegWrite = 1'b0, Busy_Set = 1'b0;
    logic [XLEN-1:0] Write_Data = '0;
    logic [XLEN-1:0] Read_Data_1, Read_Data_2, Dbg_Data;
    logic            rs1_Busy, rs2_Busy;
    logic [AW:0]     Busy_Count;

    regfile_scoreboard #(.XLEN(XLEN), .AW(AW)) dut (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
        .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2),
        .rd(rd), .RegWrite(RegWrite), .Write_Data(Write_Data),
        .Busy_Set(Busy_Set), .Busy_rd(Busy_rd),
        .rs1_Busy(rs1_Busy), .rs2_Busy(rs2_Busy),
        .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data), .Busy_Count(Busy_Count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [XLEN-1:0] rd1, rd2, dbg;
        logic            b1, b2;
        logic [AW:0]     cnt;
        int              id;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   step_id = 0;

    // Reference model state
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    function automatic logic [XLEN-1:0] m_read(int a, bit rst, bit we, int wa, logic [XLEN-1:0] wd);
        if (a == 0) return '0;
        if (!rst && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic int m_popcount();
        int c = 0;
        for (int i = 0; i < NREG; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
    endfunction

    task automatic check(string name, int id, logic [XLEN-1:0] act, logic [XLEN-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, req);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("read_data_1", e.id, Read_Data_1, e.rd1);
            check("read_data_2", e.id, Read_Data_2, e.rd2);
            check("dbg_data",    e.id, Dbg_Data,    e.dbg);
            check("rs1_busy",    e.id, {31'b0, rs1_Busy}, {31'b0, e.b1});
            check("rs2_busy",    e.id, {31'b0, rs2_Busy}, {31'b0, e.b2});
            check("busy_count",  e.id, {26'b0, Busy_Count}, {26'b0, e.cnt});
        end
    end

    // Drives one cycle of inputs shortly after a rising edge, queues the
    // expected combinational view, then advances the model across the edge.
    task automatic drive(bit rst, bit we, int wa, logic [XLEN-1:0] wd,
                         bit bs, int ba, int a1, int a2, int da);
        exp_t e;
        reset = rst; RegWrite = we; rd = AW'(wa); Write_Data = wd;
        Busy_Set = bs; Busy_rd = AW'(ba);
        rs1 = AW'(a1); rs2 = AW'(a2); Dbg_Addr = AW'(da);
        if (rst) m_clear();
        e.rd1 = m_read(a1, rst, we, wa, wd);
        e.rd2 = m_read(a2, rst, we, wa, wd);
        e.dbg = (da == 0) ? '0 : m_regs[da];
        e.b1  = m_busy[a1] && !(we && wa == a1 && wa != 0);
        e.b2  = m_busy[a2] && !(we && wa == a2 && wa != 0);
        e.cnt = (AW+1)'(m_popcount());
        e.id  = step_id++;
        exp_q.push_back(e);
        @(posedge clock);
        if (!rst) begin
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 0;
            end
            if (bs && ba != 0) m_busy[ba] = 1;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear();
        @(posedge clock); #1;
        // reset held: outputs zero even with a matching write in flight
        drive(1, 1, 4, 32'h1111_2222, 1, 4, 4, 4, 4);
        drive(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0, 5);
        drive(0, 0, 0, 0, 1, 6, 5, 6, 5);
        drive(1, 1, 5, 32'h5555_0000, 1, 5, 5, 6, 5);
        drive(0, 0, 0, 0, 0, 0, 5, 6, 5);
        // x0 hardwired
        drive(0, 1, 0, 32'h1234, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // bypass and debug port
        drive(0, 1, 7, 32'h1111, 0, 0, 0, 0, 7);
        drive(0, 1, 7, 32'hA5A5, 0, 0, 7, 7, 7);
        drive(0, 0, 0, 0, 0, 0, 7, 7, 7);
        // scoreboard set/clear
        drive(0, 0, 0, 0, 1, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 3, 3, 3);
        drive(0, 1, 3, 32'h0333, 0, 0, 3, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 3, 3, 3);
        // set-wins collision
        drive(0, 0, 0, 0, 1, 9, 0, 0, 0);
        drive(0, 1, 9, 32'h9999, 1, 9, 9, 9, 9);
        drive(0, 0, 0, 0, 0, 0, 9, 9, 9);
        // set on already-busy register
        drive(0, 0, 0, 0, 1, 9, 9, 0, 9);
        drive(0, 1, 9, 32'h9A9A, 0, 0, 9, 0, 9);
        // fill and drain all registers, including x31
        for (int i = 1; i < NREG; i++) drive(0, 0, 0, 0, 1, i, i, 31, 31);
        drive(0, 0, 0, 0, 0, 0, 31, 1, 31);
        for (int i = 1; i < NREG; i++) drive(0, 1, i, 32'hC000_0000 + i, 0, 0, i, 31, i);
        drive(0, 0, 0, 0, 0, 0, 31, 1, 31);
        // random traffic
        for (int n = 0; n < 500; n++) begin
            int wa, ba, a1, a2;
            wa = $urandom_range(0, NREG-1);
            ba = $urandom_range(0, NREG-1);
            a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, NREG-1);
            a2 = ($urandom_range(0, 3) == 0) ? ba : $urandom_range(0, NREG-1);
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 1), wa, $urandom,
                  $urandom_range(0, 1), ba, a1, a2, $urandom_range(0, NREG-1));
        end
        reset = 1'b0; RegWrite = 1'b0; Busy_Set = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the pipelined RISC-V core, generalising the single-cycle register file. It adds:
- configurable data width and register count;
- hardwired-zero x0;
- write-to-read bypass for the writeback stage;
- a per-register pending-write scoreboard that the decode stage uses for hazard detection.

It sits between decode (read/issue) and writeback (write/retire). It also exposes a debug read port and a pending-write count.

## Interface
Parameters:
- XLEN, 64, register data width in bits.
- AW, 5, register address width; the file holds NREG = 2**AW registers.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all registers, busy bits and the count immediately.
- rs1  in  AW  read address, port 1.
- rs2  in  AW  read address, port 2.
- Read_Data_1  out  XLEN  read data, port 1 (combinational).
- Read_Data_2  out  XLEN  read data, port 2 (combinational).
- rd  in  AW  writeback destination address.
- RegWrite  in  1  writeback enable.
- Write_Data  in  XLEN  writeback data.
- Busy_Set  in  1  issue strobe; marks Busy_rd as pending.
- Busy_rd  in  AW  destination of the instruction being issued.
- rs1_Busy  out  1  rs1 has an outstanding write not satisfiable this cycle.
- rs2_Busy  out  1  rs2 has an outstanding write not satisfiable this cycle.
- Dbg_Addr  in  AW  debug read address.
- Dbg_Data  out  XLEN  debug read data (raw array contents, no bypass).
- Busy_Count  out  AW+1  registered number of set busy bits.

## Operation
**Storage**
- Array of NREG × XLEN registers.
- Register 0 always reads 0. Writes and busy-sets addressed to 0 are ignored.

**Write**
- At the rising edge with RegWrite=1 and rd≠0, register rd takes Write_Data.

**Read (combinational)**
- Read_Data_N = 0 if rsN=0.
- Otherwise, Read_Data_N = Write_Data if RegWrite=1 and rd=rsN (bypass).
- Otherwise, Read_Data_N = array[rsN].

**Scoreboard**
- One busy bit per register; bit 0 is constant 0.
- Clear: RegWrite=1, rd≠0 clears busy[rd] at the edge.
- Set: Busy_Set=1, Busy_rd≠0 sets busy[Busy_rd] at the edge.
- Set and clear of the same register in the same cycle: set wins, so the bit stays 1 because a new producer was issued.
- Set of an already-busy register: the bit stays 1 (no nesting count).
- rsN_Busy = busy[rsN] AND NOT (RegWrite AND rd=rsN AND rd≠0). The same-cycle writeback is satisfied by the bypass.

**Busy_Count**
- Register equal to the popcount of the next-state busy vector, so it tracks the busy bits one-for-one after each edge.
- Range 0..NREG-1.

**Debug port**
- Dbg_Data = array[Dbg_Addr], with 0 returned for address 0.
- Combinational, no bypass.

## Timing
- Reads, bypass, rsN_Busy and Dbg_Data: combinational, zero-cycle latency.
- Write, busy update and Busy_Count: visible one cycle after the edge at which they are sampled.

**Reset values**
- All array entries 0, all busy bits 0, Busy_Count 0.
- Therefore every output reads 0 while reset is held, for any addresses.

**Reset behaviour**
- Reset asserted mid-operation aborts any in-flight write at that edge.
- Reset dominates RegWrite and Busy_Set.
- After deassertion, the first rising edge behaves normally.

**Inputs with enable low**
- Busy_rd is don't-care when Busy_Set=0.
- rd and Write_Data are don't-care when RegWrite=0.

**Boundary and corner cases**
- Highest register (NREG-1) behaves identically to all others.
- Address arithmetic does not wrap; no address is out of range by construction.
- Simultaneous Busy_Set and RegWrite to different registers: both take effect, and Busy_Count reflects the net change (+1, −1, or 0 as the bits dictate).

## Test plan
- **Reset clears state:** write 0xDEAD_BEEF to x5, then assert reset asynchronously mid-cycle → Read_Data_1 for rs1=5 is 0 immediately; Busy_Count=0.
- **x0 is hardwired:** RegWrite=1, rd=0, Write_Data=0x1234, Busy_Set with Busy_rd=0 → reads of x0 return 0; rs1_Busy=0 for rs1=0; Busy_Count unchanged.
- **Bypass:**
  - RegWrite=1, rd=7, Write_Data=0xA5A5, rs1=rs2=7 in the same cycle → both read ports show 0xA5A5 before the edge.
  - Dbg_Data for address 7 shows the old value until the edge, then 0xA5A5.
- **Scoreboard set/clear:**
  - Busy_Set with Busy_rd=3 → next cycle rs1_Busy=1 for rs1=3 and Busy_Count=1.
  - Then RegWrite with rd=3 → rs1_Busy=0 that same cycle; next cycle the busy bit is clear and Busy_Count=0.
- **Set-wins collision:** with busy[9]=1, apply Busy_Set with Busy_rd=9 and RegWrite with rd=9 in the same cycle → after the edge busy[9]=1, Busy_Count unchanged, and x9 holds the new data.
- **Fill all registers:** issue Busy_Set for x1..x31 on consecutive cycles with XLEN=32 and AW=5 → Busy_Count reaches 31; retire them all → Busy_Count returns to 0.
